// File: rtl/exec_ctrl.sv
// Execution controller: single-step, counted burst and rate-limited free-run
// commit sequencing with hardware breakpoint comparators.
module exec_ctrl #(
  parameter int PC_W   = 32,
  parameter int NUM_BP = 4,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step_pulse,
  input  logic                   run_req,
  input  logic                   halt_req,
  input  logic [1:0]             mode,
  input  logic [CNT_W-1:0]       burst_len,
  input  logic [DIV_W-1:0]       rate_div,
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  output logic                   pc_wen,
  output logic                   busy,
  output logic                   bp_hit,
  output logic [2:0]             bp_idx,
  output logic [31:0]            retired
);

  // Encoding chosen so busy is bit 1 and bp_hit is bit 2 of the state flop.
  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_BURST   = 3'b010,
    S_RUN     = 3'b011,
    S_BP_HALT = 3'b100
  } state_t;

  state_t           r_state;
  logic             r_pc_wen;
  logic [2:0]       r_bp_idx;
  logic [31:0]      r_retired;
  logic [CNT_W-1:0] r_rem;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_rate;
  logic             r_skip;

  logic [NUM_BP-1:0] w_match;
  logic              w_bp_any;
  logic [2:0]        w_bp_first;
  logic              w_bp_stop;

  // pc is the address the next pc_wen cycle would commit.
  for (genvar g = 0; g < NUM_BP; g++) begin : g_cmp
    assign w_match[g] = bp_en[g] && (pc == bp_addr[g*PC_W +: PC_W]);
  end

  // Lowest-numbered matching comparator wins.
  always_comb begin
    w_bp_any   = 1'b0;
    w_bp_first = 3'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      w_bp_any   = w_bp_any | w_match[i];
      w_bp_first = w_match[i] ? 3'(i) : w_bp_first;
    end
  end

  assign w_bp_stop = w_bp_any & ~r_skip;

  // Control FSM with registered commit strobe and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc_wen  <= 1'b0;
      r_bp_idx  <= 3'd0;
      r_retired <= 32'd0;
      r_rem     <= '0;
      r_div     <= '0;
      r_rate    <= '0;
      r_skip    <= 1'b0;
    end else begin
      r_pc_wen <= 1'b0;
      if (r_pc_wen) begin
        r_retired <= r_retired + 32'd1;
      end
      case (r_state)
        S_IDLE, S_BP_HALT: begin
          if (halt_req) begin
            r_state <= S_IDLE;
          end else if (run_req) begin
            r_skip <= 1'b1;
            case (mode)
              2'b01: begin
                r_rem   <= burst_len;
                r_state <= (burst_len == '0) ? S_IDLE : S_BURST;
              end
              2'b10: begin
                r_div   <= '0;
                r_rate  <= rate_div;
                r_state <= S_RUN;
              end
              default: begin
                r_pc_wen <= 1'b1;
                r_state  <= S_IDLE;
              end
            endcase
          end else if (step_pulse) begin
            r_pc_wen <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_state <= r_state;
          end
        end
        S_BURST: begin
          if (halt_req || (r_rem == '0)) begin
            r_state <= S_IDLE;
          end else if (w_bp_stop) begin
            r_bp_idx <= w_bp_first;
            r_state  <= S_BP_HALT;
          end else begin
            r_pc_wen <= 1'b1;
            r_skip   <= 1'b0;
            r_rem    <= r_rem - CNT_W'(1);
          end
        end
        S_RUN: begin
          if (halt_req) begin
            r_state <= S_IDLE;
          end else if (r_div == r_rate) begin
            if (w_bp_stop) begin
              r_bp_idx <= w_bp_first;
              r_state  <= S_BP_HALT;
            end else begin
              r_pc_wen <= 1'b1;
              r_skip   <= 1'b0;
              r_div    <= '0;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pc_wen  = r_pc_wen;
  assign busy    = r_state[1];
  assign bp_hit  = r_state[2];
  assign bp_idx  = r_bp_idx;
  assign retired = r_retired;

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: vector table, directed corner sequences
// and randomized traffic against a behavioural reference model.
module tb_exec_ctrl;
  localparam int PC_W = 32, NUM_BP = 4, CNT_W = 16, DIV_W = 24;
  localparam int K_IDLE = 0, K_BURST = 1, K_RUN = 2, K_HALT = 3;

  logic clk = 1'b0;
  logic rst, step_pulse, run_req, halt_req;
  logic [1:0] mode;
  logic [CNT_W-1:0] burst_len;
  logic [DIV_W-1:0] rate_div;
  logic [PC_W-1:0] pc, core_pc;
  logic [NUM_BP-1:0] bp_en;
  logic [NUM_BP*PC_W-1:0] bp_addr;
  logic pc_wen, busy, bp_hit;
  logic [2:0] bp_idx;
  logic [31:0] retired;

  int n_vec = 0;
  int n_err = 0;

  exec_ctrl #(.PC_W(PC_W), .NUM_BP(NUM_BP), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .step_pulse(step_pulse), .run_req(run_req),
    .halt_req(halt_req), .mode(mode), .burst_len(burst_len), .rate_div(rate_div),
    .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr), .pc_wen(pc_wen), .busy(busy),
    .bp_hit(bp_hit), .bp_idx(bp_idx), .retired(retired)
  );

  always #5 clk = ~clk;

  // Core stand-in: 4-byte instructions, pc presents the next address to commit.
  always @(posedge clk) begin
    if (rst) core_pc <= '0;
    else if (pc_wen) core_pc <= core_pc + 32'd4;
  end
  assign pc = core_pc + (pc_wen ? 32'd4 : 32'd0);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int m_kind, m_left, m_cnt, m_rate, m_idx;
  bit m_skip, m_wen;
  logic [31:0] m_ret;

  function automatic int first_bp(input logic [PC_W-1:0] p);
    for (int i = 0; i < NUM_BP; i++)
      if (bp_en[i] && bp_addr[i*PC_W +: PC_W] == p) return i;
    return -1;
  endfunction

  task automatic model_step();
    bit nw, due;
    int b;
    nw = 1'b0;
    if (rst) begin
      m_kind = K_IDLE; m_wen = 1'b0; m_ret = 32'd0; m_idx = 0;
      m_left = 0; m_cnt = 0; m_rate = 0; m_skip = 1'b0;
      return;
    end
    if (m_wen) m_ret = m_ret + 32'd1;
    if (halt_req) m_kind = K_IDLE;
    else if (m_kind == K_IDLE || m_kind == K_HALT) begin
      if (run_req && mode == 2'b01) begin
        m_left = int'(burst_len); m_skip = 1'b1;
        m_kind = (burst_len == 0) ? K_IDLE : K_BURST;
      end else if (run_req && mode == 2'b10) begin
        m_cnt = 0; m_rate = int'(rate_div); m_skip = 1'b1; m_kind = K_RUN;
      end else if (run_req || step_pulse) begin
        nw = 1'b1; m_kind = K_IDLE;
      end
    end else begin
      due = (m_kind == K_BURST) ? (m_left > 0) : (m_cnt == m_rate);
      if (m_kind == K_BURST && m_left == 0) m_kind = K_IDLE;
      else if (due) begin
        b = first_bp(pc);
        if (!m_skip && b >= 0) begin
          m_kind = K_HALT; m_idx = b;
        end else begin
          nw = 1'b1; m_skip = 1'b0;
          if (m_kind == K_BURST) m_left--; else m_cnt = 0;
        end
      end else m_cnt++;
    end
    m_wen = nw;
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rst = 1'b0; step_pulse = 1'b0; run_req = 1'b0; halt_req = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input int cyc);
    chk($sformatf("rnd%0d.pc_wen", cyc), 32'(pc_wen), 32'(m_wen));
    chk($sformatf("rnd%0d.busy", cyc), 32'(busy), 32'(m_kind == K_BURST || m_kind == K_RUN));
    chk($sformatf("rnd%0d.bp_hit", cyc), 32'(bp_hit), 32'(m_kind == K_HALT));
    chk($sformatf("rnd%0d.bp_idx", cyc), 32'(bp_idx), 32'(m_idx));
    chk($sformatf("rnd%0d.retired", cyc), retired, m_ret);
  endtask

  task automatic do_reset();
    clr(); rst = 1'b1; tick(); clr();
  endtask

  typedef struct {
    logic r, h, u, s;
    logic [1:0] md;
    logic [CNT_W-1:0] bl;
    logic [DIV_W-1:0] rd;
    logic ew, eb, eh;
    logic [31:0] er;
  } vec_t;

  function automatic vec_t mk(input logic r, h, u, s, input logic [1:0] md,
                              input int bl, rd, input logic ew, eb, eh, input int er);
    vec_t v;
    v.r = r; v.h = h; v.u = u; v.s = s; v.md = md;
    v.bl = bl[CNT_W-1:0]; v.rd = rd[DIV_W-1:0];
    v.ew = ew; v.eb = eb; v.eh = eh; v.er = er[31:0];
    return v;
  endfunction

  vec_t tbl[22];

  initial begin
    int cnt, first, last, prev, nviol;
    bit seen;
    bit wen_h[24];
    bit busy_h[24];

    // rst halt run step mode blen rdiv | pc_wen busy bp_hit retired
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 0, 0, 1'b1, 1'b0, 1'b0, 0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 1);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0, 0, 1'b1, 1'b0, 1'b0, 1);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 2);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 0, 0, 1'b1, 1'b0, 1'b0, 2);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 3);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 0, 0, 1'b0, 1'b0, 1'b0, 3);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2, 0, 1'b0, 1'b1, 1'b0, 3);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b1, 1'b1, 1'b0, 3);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b1, 1'b1, 1'b0, 4);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 5);
    tbl[12] = mk(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 5);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 0, 1, 1'b0, 1'b1, 1'b0, 5);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 1'b1, 1'b0, 5);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b1, 1'b1, 1'b0, 5);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 0, 0, 1'b0, 1'b1, 1'b0, 6);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b1, 1'b1, 1'b0, 6);
    tbl[18] = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 7);
    tbl[19] = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 3, 0, 1'b0, 1'b1, 1'b0, 7);
    tbl[20] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 0);

    clr(); mode = 2'd0; burst_len = '0; rate_div = '0; bp_en = '0; bp_addr = '0;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 22; i++) begin
      rst = tbl[i].r; halt_req = tbl[i].h; run_req = tbl[i].u; step_pulse = tbl[i].s;
      mode = tbl[i].md; burst_len = tbl[i].bl; rate_div = tbl[i].rd;
      tick();
      clr();
      chk($sformatf("tbl%0d.pc_wen", i), 32'(pc_wen), 32'(tbl[i].ew));
      chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d.bp_hit", i), 32'(bp_hit), 32'(tbl[i].eh));
      chk($sformatf("tbl%0d.bp_idx", i), 32'(bp_idx), 32'd0);
      chk($sformatf("tbl%0d.retired", i), retired, tbl[i].er);
    end

    // Burst of 5
    do_reset();
    mode = 2'b01; burst_len = 16'd5; run_req = 1'b1; tick(); clr();
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      wen_h[c] = pc_wen; busy_h[c] = busy;
      if (pc_wen) begin cnt++; if (first < 0) first = c; last = c; end
      tick();
    end
    chk("burst.count", 32'(cnt), 32'd5);
    chk("burst.span", 32'(last - first), 32'd4);
    chk("burst.busy_on_5th", (last >= 0) ? 32'(busy_h[last]) : 32'hDEAD, 32'd1);
    chk("burst.busy_after", (last >= 0) ? 32'(busy_h[last+1]) : 32'hDEAD, 32'd0);
    chk("burst.retired", retired, 32'd5);

    // Free-run every 4 cycles, then halt
    do_reset();
    mode = 2'b10; rate_div = 24'd3; run_req = 1'b1; tick(); clr();
    cnt = 0; prev = -1; nviol = 0;
    for (int c = 0; c < 22; c++) begin
      if (pc_wen) begin
        if (prev >= 0 && c - prev != 4) nviol++;
        prev = c; cnt++;
      end
      tick();
    end
    chk("run.commits", 32'(cnt), 32'd5);
    chk("run.spacing_errors", 32'(nviol), 32'd0);
    halt_req = 1'b1; tick(); clr();
    chk("run.halt_wen", 32'(pc_wen), 32'd0);
    chk("run.halt_busy", 32'(busy), 32'd0);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin if (pc_wen) cnt++; tick(); end
    chk("run.after_halt", 32'(cnt), 32'd0);

    // Breakpoint at 0x10 on comparator 1
    do_reset();
    bp_en = 4'b0010; bp_addr = '0; bp_addr[1*PC_W +: PC_W] = 32'h0000_0010;
    mode = 2'b01; burst_len = 16'd10; run_req = 1'b1; tick(); clr();
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (bp_hit) seen = 1'b1; else tick();
    end
    chk("bp.seen", 32'(seen), 32'd1);
    chk("bp.idx", 32'(bp_idx), 32'd1);
    chk("bp.retired", retired, 32'd4);
    chk("bp.core_pc", core_pc, 32'h10);
    chk("bp.busy", 32'(busy), 32'd0);
    burst_len = 16'd1; run_req = 1'b1; tick(); clr();
    tick();
    chk("bp.resume_wen", 32'(pc_wen), 32'd1);
    chk("bp.resume_hit", 32'(bp_hit), 32'd0);
    tick();
    chk("bp.resume_pc", core_pc, 32'h14);
    chk("bp.resume_ret", retired, 32'd5);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 20 == 0) begin
        bp_en = 4'($urandom);
        for (int k = 0; k < NUM_BP; k++)
          bp_addr[k*PC_W +: PC_W] = core_pc + 32'(4 * $urandom_range(0, 12));
      end
      rst = ($urandom_range(0, 299) == 0);
      halt_req = ($urandom_range(0, 39) == 0);
      run_req = ($urandom_range(0, 7) == 0);
      step_pulse = ($urandom_range(0, 9) == 0);
      mode = 2'($urandom);
      burst_len = 16'($urandom_range(0, 6));
      rate_div = 24'($urandom_range(0, 3));
      tick();
      clr();
      chk_model(c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
